// File: rtl/tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator: channel state
// encoding and the default sizing constants used by the top level.
package tick_gen_pkg;

  // Per-channel sequencing state. DONE is only reached in one-shot mode.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chan_state_t;

  localparam int DEF_NCHAN  = 4;
  localparam int DEF_INT_W  = 8;
  // The fractional accumulator must be at least one bit wide.
  localparam int DEF_FRAC_W = 8;

endpackage

// File: rtl/tick_gen_chan.sv
// One timebase channel: fractional divider (integer down-counter plus a
// fractional phase accumulator whose carry stretches a period by one cycle),
// IDLE/RUN/DONE sequencing and registered pulse / NRZ outputs.
module tick_gen_chan
  import tick_gen_pkg::*;
#(
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              oneshot,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              rs,
  output logic              tick_pulse,
  output logic              tick_nrz,
  output logic              running
);

  localparam logic [INT_W:0] CTR_ONE = {{INT_W{1'b0}}, 1'b1};

  chan_state_t       state_reg, state_next;
  logic [INT_W:0]    ctr_reg, ctr_next;
  logic [FRAC_W-1:0] acc_reg, acc_next;
  logic              pulse_reg, nrz_reg, running_reg;

  logic              go;
  logic              evt;
  logic [FRAC_W:0]   acc_sum;
  logic [INT_W:0]    reload_val;

  assign go = en && (div_int != '0);

  // Carry out of the accumulator adds one cycle to the next period; the
  // reload is one bit wider than the divisor so int=max plus carry fits.
  assign acc_sum    = {1'b0, acc_reg} + {1'b0, div_frac};
  assign reload_val = {1'b0, div_int} + {{INT_W{1'b0}}, acc_sum[FRAC_W]};

  // Next-state, counter and accumulator update; disable beats restart, and
  // restart beats an event on the same cycle.
  always_comb begin
    state_next = state_reg;
    ctr_next   = ctr_reg;
    acc_next   = acc_reg;
    evt        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (go) begin
          state_next = ST_RUN;
          ctr_next   = {1'b0, div_int};
          acc_next   = '0;
        end
      end
      ST_RUN: begin
        if (!go) begin
          state_next = ST_IDLE;
          ctr_next   = '0;
          acc_next   = '0;
        end else if (rs) begin
          ctr_next = {1'b0, div_int};
          acc_next = '0;
        end else if (ctr_reg == CTR_ONE) begin
          evt      = 1'b1;
          acc_next = acc_sum[FRAC_W-1:0];
          if (oneshot) begin
            state_next = ST_DONE;
          end else begin
            ctr_next = reload_val;
          end
        end else begin
          ctr_next = ctr_reg - CTR_ONE;
        end
      end
      ST_DONE: begin
        if (!go) begin
          state_next = ST_IDLE;
          ctr_next   = '0;
          acc_next   = '0;
        end else if (rs) begin
          state_next = ST_RUN;
          ctr_next   = {1'b0, div_int};
          acc_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        ctr_next   = '0;
        acc_next   = '0;
      end
    endcase
  end

  // State and output registers; the NRZ level is cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      ctr_reg     <= '0;
      acc_reg     <= '0;
      pulse_reg   <= 1'b0;
      nrz_reg     <= 1'b0;
      running_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ctr_reg     <= ctr_next;
      acc_reg     <= acc_next;
      pulse_reg   <= evt;
      nrz_reg     <= nrz_reg ^ evt;
      running_reg <= (state_next == ST_RUN);
    end
  end

  assign tick_pulse = pulse_reg;
  assign tick_nrz   = nrz_reg;
  assign running    = running_reg;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel timebase generator. Each channel divides clk by
// int + frac/2^FRAC_W independently; restart_all realigns all phases.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NCHAN  = DEF_NCHAN,
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCHAN-1:0]        cfg_en,
  input  logic [NCHAN-1:0]        cfg_oneshot,
  input  logic [NCHAN*INT_W-1:0]  cfg_int,
  input  logic [NCHAN*FRAC_W-1:0] cfg_frac,
  input  logic [NCHAN-1:0]        restart,
  input  logic                    restart_all,
  output logic [NCHAN-1:0]        tick_pulse,
  output logic [NCHAN-1:0]        tick_nrz,
  output logic [NCHAN-1:0]        running
);

  // One channel per slice of the packed configuration vectors.
  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
    tick_gen_chan #(
      .INT_W  (INT_W),
      .FRAC_W (FRAC_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .en         (cfg_en[gi]),
      .oneshot    (cfg_oneshot[gi]),
      .div_int    (cfg_int[gi*INT_W +: INT_W]),
      .div_frac   (cfg_frac[gi*FRAC_W +: FRAC_W]),
      .rs         (restart[gi] | restart_all),
      .tick_pulse (tick_pulse[gi]),
      .tick_nrz   (tick_nrz[gi]),
      .running    (running[gi])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: stimulus pushes expected (channel, cycle,
// nrz) tick records; a negedge monitor pops and compares each observed pulse.
// Cycle labels: inputs present in cycle n are sampled at posedge n; a value
// registered at posedge k is visible during cycle k+1.
module tb_tick_gen;

  localparam int NCHAN  = 4;
  localparam int INT_W  = 8;
  localparam int FRAC_W = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NCHAN-1:0]        cfg_en;
  logic [NCHAN-1:0]        cfg_oneshot;
  logic [NCHAN*INT_W-1:0]  cfg_int;
  logic [NCHAN*FRAC_W-1:0] cfg_frac;
  logic [NCHAN-1:0]        restart;
  logic                    restart_all;
  logic [NCHAN-1:0]        tick_pulse;
  logic [NCHAN-1:0]        tick_nrz;
  logic [NCHAN-1:0]        running;

  tick_gen #(.NCHAN(NCHAN), .INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_en      (cfg_en),
    .cfg_oneshot (cfg_oneshot),
    .cfg_int     (cfg_int),
    .cfg_frac    (cfg_frac),
    .restart     (restart),
    .restart_all (restart_all),
    .tick_pulse  (tick_pulse),
    .tick_nrz    (tick_nrz),
    .running     (running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   ch;
    int   cyc;
    logic nrz;
  } exp_t;

  exp_t             sb[$];
  logic [NCHAN-1:0] exp_nrz = '0;
  int               pulse_cnt[NCHAN];
  int               checks = 0;
  int               errors = 0;

  initial for (int i = 0; i < NCHAN; i++) pulse_cnt[i] = 0;

  // Monitor: every observed pulse must match the oldest expectation for its channel.
  always @(negedge clk) begin : mon
    int idx;
    for (int ch = 0; ch < NCHAN; ch++) begin
      if (tick_pulse[ch] !== 1'b0) begin
        pulse_cnt[ch] = pulse_cnt[ch] + 1;
        idx = -1;
        for (int j = 0; j < sb.size(); j++) begin
          if (idx < 0 && sb[j].ch == ch) idx = j;
        end
        checks = checks + 1;
        if (idx < 0) begin
          errors = errors + 1;
          $display("FAIL tick_ch%0d unexpected pulse actual cycle=%0d required none", ch, cyc + 1);
        end else begin
          if (sb[idx].cyc != cyc + 1 || tick_nrz[ch] !== sb[idx].nrz) begin
            errors = errors + 1;
            $display("FAIL tick_ch%0d actual cycle=%0d nrz=%0b required cycle=%0d nrz=%0b",
                     ch, cyc + 1, tick_nrz[ch], sb[idx].cyc, sb[idx].nrz);
          end else begin
            $display("tick ch=%0d cycle=%0d nrz=%0b", ch, cyc + 1, tick_nrz[ch]);
          end
          sb.delete(idx);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("check %s = %0d", name, act);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Label of the cycle whose inputs are being driven right now.
  function automatic int cur();
    return cyc + 1;
  endfunction

  task automatic wait_until(input int c);
    while (cur() < c) step(1);
  endtask

  task automatic push(input int ch, input int c);
    exp_nrz[ch] = ~exp_nrz[ch];
    sb.push_back('{ch, c, exp_nrz[ch]});
  endtask

  task automatic set_div(input int ch, input int iv, input int fv);
    cfg_int[ch*INT_W +: INT_W]    = iv[INT_W-1:0];
    cfg_frac[ch*FRAC_W +: FRAC_W] = fv[FRAC_W-1:0];
  endtask

  initial begin
    int n, m, e, base;
    rst = 1'b1; cfg_en = '0; cfg_oneshot = '0; cfg_int = '0; cfg_frac = '0;
    restart = '0; restart_all = 1'b0;
    step(3);
    check("rst_pulse", int'(tick_pulse), 0);
    check("rst_nrz", int'(tick_nrz), 0);
    check("rst_running", int'(running), 0);
    rst = 1'b0;
    step(2);

    // int=4: ticks at n+5, n+9, n+13; disabled mid-period afterwards.
    set_div(0, 4, 0); cfg_en[0] = 1'b1; n = cur();
    push(0, n + 5); push(0, n + 9); push(0, n + 13);
    check("t1_running_n", int'(running[0]), 0);
    step(1);
    check("t1_running_n1", int'(running[0]), 1);
    wait_until(n + 14);
    cfg_en[0] = 1'b0;
    step(1);
    check("t1_dis_running", int'(running[0]), 0);
    check("t1_dis_nrz", int'(tick_nrz[0]), 1);
    step(6);

    // int=1, frac=0: every cycle; disable on an event cycle gives no tick.
    set_div(2, 1, 0); cfg_en[2] = 1'b1; n = cur();
    for (int k = 2; k <= 5; k++) push(2, n + k);
    wait_until(n + 5);
    cfg_en[2] = 1'b0;
    step(4);

    // int=1, frac=0.5: spacings 1,2,...; 200 pulses in 300 cycles.
    set_div(1, 1, 8'h80); cfg_en[1] = 1'b1; n = cur(); base = pulse_cnt[1];
    for (int k = 0; k < 100; k++) begin
      push(1, n + 2 + 3 * k);
      push(1, n + 3 + 3 * k);
    end
    wait_until(n + 301);
    cfg_en[1] = 1'b0;
    step(3);
    check("t2_pulse_count", pulse_cnt[1] - base, 200);

    // One-shot int=3, then a per-channel restart from DONE.
    set_div(2, 3, 0); cfg_oneshot[2] = 1'b1; cfg_en[2] = 1'b1; n = cur();
    push(2, n + 4);
    wait_until(n + 3);
    check("t3_running_before", int'(running[2]), 1);
    step(1);
    check("t3_running_done", int'(running[2]), 0);
    wait_until(n + 12);
    restart[2] = 1'b1; m = cur();
    push(2, m + 4);
    step(1);
    restart[2] = 1'b0;
    wait_until(m + 12);
    check("t3_running_end", int'(running[2]), 0);
    cfg_en[2] = 1'b0; cfg_oneshot[2] = 1'b0;
    step(2);

    // int=5 / int=7; restart_all lands on a channel-0 event cycle.
    set_div(0, 5, 0); set_div(1, 7, 0); cfg_en[1:0] = 2'b11; e = cur();
    push(0, e + 6); push(0, e + 11); push(0, e + 16);
    push(1, e + 8); push(1, e + 15);
    wait_until(e + 20);
    restart_all = 1'b1; n = cur();
    push(0, n + 6); push(0, n + 11); push(0, n + 16);
    push(1, n + 8); push(1, n + 15);
    step(1);
    restart_all = 1'b0;
    wait_until(n + 16);
    cfg_en[1:0] = 2'b00;
    step(4);

    // int=0 with enable set: channel never runs.
    set_div(3, 0, 0); cfg_en[3] = 1'b1;
    step(20);
    check("t5_int0_running", int'(running[3]), 0);
    cfg_en[3] = 1'b0;

    // Reset while running with a non-zero accumulator.
    set_div(1, 3, 8'h40); cfg_en[1] = 1'b1; n = cur();
    push(1, n + 4); push(1, n + 7);
    wait_until(n + 8);
    rst = 1'b1; cfg_en[1] = 1'b0;
    step(1);
    exp_nrz = '0;
    check("t6_rst_pulse", int'(tick_pulse), 0);
    check("t6_rst_nrz", int'(tick_nrz), 0);
    check("t6_rst_running", int'(running), 0);
    rst = 1'b0;
    step(2);
    cfg_en[1] = 1'b1; m = cur();
    push(1, m + 4); push(1, m + 7); push(1, m + 10); push(1, m + 13); push(1, m + 17);
    wait_until(m + 18);
    cfg_en[1] = 1'b0;
    step(5);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
Name: tick_gen

Overview:
Parametrised multi-channel timebase generator, successor to the single fixed-divider timer tick in the system config block.
- Each channel divides clk by a fractional divisor INT + FRAC/2^FRAC_W.
- Each channel drives a registered single-cycle pulse and an NRZ toggle output, in free-running or one-shot mode.
- Config comes from register-block outputs. Ticks feed mtime, APU sample clocks and PPU line timers.

Parameters:
NCHAN, 4, number of independent channels
INT_W, 8, integer divisor width
FRAC_W, 8, fractional accumulator width (0 is not allowed; minimum 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_en  in  NCHAN  per-channel enable
cfg_oneshot  in  NCHAN  1 = stop after first tick following start/restart
cfg_int  in  NCHAN*INT_W  integer divisor, channel i at [i*INT_W +: INT_W]; 0 = channel held idle
cfg_frac  in  NCHAN*FRAC_W  fractional divisor, channel i at [i*FRAC_W +: FRAC_W]
restart  in  NCHAN  per-channel restart strobe
restart_all  in  1  restart every channel on the same cycle (phase alignment)
tick_pulse  out  NCHAN  registered one-cycle pulse per tick
tick_nrz  out  NCHAN  registered level, toggles once per tick
running  out  NCHAN  1 while the channel is in RUN

Behaviour:
- Reset (rst sampled high at a clk edge): all channels go to IDLE with ctr=0 and acc=0. tick_pulse=0, tick_nrz=0, running=0.
- Per-channel state: ctr (INT_W+1 bits), acc (FRAC_W bits), FSM {IDLE, RUN, DONE}.
- go = cfg_en[i] && cfg_int[i]!=0. rs = restart[i] || restart_all.
- IDLE: go → RUN with ctr<=int, acc<=0. Otherwise stay in IDLE.
- RUN:
  - !go → IDLE with ctr<=0, acc<=0, no tick. A mid-period disable produces no tick.
  - rs → ctr<=int, acc<=0, stay in RUN. Restart beats an event on the same cycle: no tick is issued.
  - Event (ctr==1, !rs):
    - {c,acc} <= acc + frac.
    - Tick is registered for next cycle.
    - oneshot → DONE. Otherwise ctr <= int + c.
    - The carry stretches the following period by 1 cycle.
  - Otherwise ctr <= ctr-1.
- DONE:
  - !go → IDLE.
  - rs && go → RUN with ctr<=int, acc<=0.
  - Otherwise hold; no ticks.
- Tick outputs:
  - tick_pulse <= event, so it is high for exactly one cycle per event.
  - tick_nrz <= tick_nrz ^ event. The NRZ level is never reset by disable or restart, only by rst.
- Timing:
  - go or rs sampled at cycle n → RUN with ctr=int at n+1 → first event at n+int → tick_pulse high at n+int+1.
  - The first period is always exactly int cycles; later periods are int or int+1.
  - Long-run mean period = int + frac/2^FRAC_W.
- int=1, frac=0: tick_pulse is high every cycle from n+2 onward, and tick_nrz toggles every cycle.
- Config changes (int, frac, oneshot) during RUN take effect at the next reload. The current period always completes.
- running = (state==RUN), registered.
- Channels are fully independent; only restart_all is shared.
- Width rule: int+c is computed in INT_W+1 bits, so int = 2^INT_W-1 with carry loads 2^INT_W without overflow.

Decomposition:
- Shared package tick_gen_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default parameter constants.
- Sub-module tick_gen_chan: one channel's FSM, counter, accumulator and output flops, scalar ports.
- Top level: a generate loop over NCHAN that slices the cfg vectors and ORs restart_all into each channel's rs.

Test Plan:
- Reset then cfg_en[0]=1, int=4, frac=0 at cycle n → tick_pulse[0] at n+5, n+9, n+13; tick_nrz[0] toggles on the same cycles; running[0]=1 from n+1.
- int=1, frac=0x80 (FRAC_W=8), enabled at n → tick spacings 1,2,1,2,…; exactly 200 pulses in any 300-cycle window after the first tick.
- oneshot=1, int=3, enabled at n → a single pulse at n+4, running drops at n+4, no further ticks; restart at m → one pulse at m+4.
- Channels 0 and 1 running with int=5 and int=7; restart_all at n → first pulses at n+6 and n+8; restart asserted on an event cycle → no pulse that cycle.
- cfg_en dropped mid-period → no pulse, running=0 next cycle, tick_nrz unchanged; int=0 with cfg_en=1 → no pulses ever.
- rst asserted while in RUN with acc≠0 → all outputs 0 next cycle; on re-enable, first period is exactly int.
